// File: rtl/as_pack.sv
// Shared types and defaults for the peripheral-bus arbiter.
package as_pack;

  localparam int gpio_addr_width = 32;
  localparam int TMO_CYC_DEF     = 15;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

endpackage

// File: rtl/as_arb_rr2.sv
// Combinational 2-way round-robin picker; a locked master 1 keeps the bus while it was last owner.
module as_arb_rr2
  import as_pack::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_lock,
  output logic       o_win,
  output logic       o_vld
);

  always_comb begin
    o_win = MST0;
    o_vld = |i_req;
    unique case (i_req)
      2'b01:   o_win = MST0;
      2'b10:   o_win = MST1;
      2'b11:   o_win = (i_lock && (i_last == MST1)) ? MST1 : ~i_last;
      default: o_win = MST0;
    endcase
  end

endmodule

// File: rtl/as_bus_arbiter.sv
// Two-master bus arbiter: grant one cycle after request, response one cycle after
// slave ready or after TMO_CYC unanswered select cycles (error response).
module as_bus_arbiter
  import as_pack::*;
#(
  parameter int ADDR_W  = gpio_addr_width,
  parameter int DATA_W  = 64,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m1_req_i,
  input  logic              m0_we_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_lock_i,
  output logic              m0_gnt_o,
  output logic              m1_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m0_err_o,
  output logic              m1_err_o,
  output logic              s_cs_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_ready_i,
  input  logic [DATA_W-1:0] s_rdata_i
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  mst_idx_t         r_owner;
  mst_idx_t         r_last;
  logic [CNT_W-1:0] r_wait;

  logic w_win;
  logic w_win_vld;
  logic w_load;
  logic w_fin_ok;
  logic w_fin_tmo;
  logic w_fin;
  logic w_resp;
  logic w_tmo_hit;

  as_arb_rr2 u_pick (
    .i_req  ({m1_req_i, m0_req_i}),
    .i_last (r_last),
    .i_lock (m1_lock_i),
    .o_win  (w_win),
    .o_vld  (w_win_vld)
  );

  // The current ACCESS cycle is the TMO_CYC-th one with no ready.
  assign w_tmo_hit = (r_wait == CNT_W'(TMO_CYC - 1));
  assign w_fin     = w_fin_ok | w_fin_tmo;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fin_ok    = 1'b0;
    w_fin_tmo   = 1'b0;
    w_resp      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_load      = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (s_ready_i) begin
          w_fin_ok    = 1'b1;
          w_state_nxt = RESP;
        end else if (w_tmo_hit) begin
          w_fin_tmo   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_owner     <= MST0;
      r_last      <= MST1;
      r_wait      <= '0;
      m0_gnt_o    <= 1'b0;
      m1_gnt_o    <= 1'b0;
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rdata_o  <= '0;
      m0_err_o    <= 1'b0;
      m1_err_o    <= 1'b0;
      s_cs_o      <= 1'b0;
      s_we_o      <= 1'b0;
      s_addr_o    <= '0;
      s_wdata_o   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      m0_gnt_o    <= w_load & (w_win == MST0);
      m1_gnt_o    <= w_load & (w_win == MST1);
      m0_rvalid_o <= w_fin & (r_owner == MST0);
      m1_rvalid_o <= w_fin & (r_owner == MST1);

      if (w_load) begin
        r_owner   <= w_win;
        r_wait    <= '0;
        s_cs_o    <= 1'b1;
        s_we_o    <= (w_win == MST1) ? m1_we_i    : m0_we_i;
        s_addr_o  <= (w_win == MST1) ? m1_addr_i  : m0_addr_i;
        s_wdata_o <= (w_win == MST1) ? m1_wdata_i : m0_wdata_i;
      end

      // Only the owner's response registers move; the other master keeps its last result.
      if (w_fin) begin
        s_cs_o <= 1'b0;
        r_wait <= '0;
        if (r_owner == MST1) begin
          m1_rdata_o <= w_fin_ok ? s_rdata_i : '0;
          m1_err_o   <= w_fin_tmo;
        end else begin
          m0_rdata_o <= w_fin_ok ? s_rdata_i : '0;
          m0_err_o   <= w_fin_tmo;
        end
      end else if (r_state == ACCESS) begin
        r_wait <= r_wait + CNT_W'(1);
      end

      if (w_resp) begin
        r_last <= r_owner;
      end
    end
  end

endmodule

// File: tb/tb_as_bus_arbiter.sv
// Bench for as_bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_as_bus_arbiter;
  import as_pack::*;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req, m0_we, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rv, m1_rv, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_cs, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ready = 1'b0;
  logic [DW-1:0] s_rdata = '0;

  always #5 clk = ~clk;

  as_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_we_i(m0_we), .m1_we_i(m1_we),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_wdata_i(m0_wdata), .m1_wdata_i(m1_wdata),
    .m1_lock_i(m1_lock),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt), .m0_rvalid_o(m0_rv), .m1_rvalid_o(m1_rv),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata), .m0_err_o(m0_err), .m1_err_o(m1_err),
    .s_cs_o(s_cs), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave responder: asserts ready on the (sl_wait+1)-th select cycle; sl_wait < 0 never answers.
  int            sl_wait = 0;
  int            sl_age  = 0;
  logic [DW-1:0] sl_data = '0;
  always @(negedge clk) begin
    if (s_cs === 1'b1) begin
      s_ready = (sl_wait >= 0) && (sl_age == sl_wait);
      sl_age++;
    end else begin
      s_ready = 1'b0;
      sl_age  = 0;
    end
    s_rdata = sl_data;
  end

  // Transaction model: who owns the bus, how long the slave has been selected, what each master last got.
  bit            model_on = 0;
  int            b_own = 0, b_last = 1, b_age = 0;
  bit            e_cs = 0;
  bit            e_gnt [2];
  bit            e_rv  [2];
  logic          b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic [DW-1:0] e_rdata [2];
  logic          e_err   [2];

  int            g_m[$], g_c[$], r_m[$], r_c[$], r_e[$];
  logic [DW-1:0] r_d[$];
  int            cs_hi = 0;

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [DW-1:0] qdat(input logic [DW-1:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction

  always @(posedge clk) begin
    bit was_rv;
    int w;
    #1;
    cyc++;
    was_rv   = e_rv[0] || e_rv[1];
    e_gnt[0] = 0; e_gnt[1] = 0; e_rv[0] = 0; e_rv[1] = 0;
    if (rst) begin
      model_on = 1;
      b_last = 1; b_age = 0; e_cs = 0;
      b_we = 1'b0; b_addr = '0; b_wdata = '0;
      for (int i = 0; i < 2; i++) begin e_rdata[i] = '0; e_err[i] = 1'b0; end
    end else if (e_cs) begin
      b_age++;
      if (s_ready) begin
        e_cs = 0; e_rv[b_own] = 1; e_rdata[b_own] = s_rdata; e_err[b_own] = 1'b0;
      end else if (b_age == TMO) begin
        e_cs = 0; e_rv[b_own] = 1; e_rdata[b_own] = '0; e_err[b_own] = 1'b1;
      end
    end else if (was_rv) begin
      b_last = b_own;
    end else if (m0_req || m1_req) begin
      if (m0_req && m1_req) w = (m1_lock && b_last == 1) ? 1 : 1 - b_last;
      else                  w = m1_req ? 1 : 0;
      b_own = w; b_age = 0; e_gnt[w] = 1; e_cs = 1;
      b_we    = w ? m1_we    : m0_we;
      b_addr  = w ? m1_addr  : m0_addr;
      b_wdata = w ? m1_wdata : m0_wdata;
    end
    if (model_on) begin
      chk("gnt0", m0_gnt, e_gnt[0]);
      chk("gnt1", m1_gnt, e_gnt[1]);
      chk("rvalid0", m0_rv, e_rv[0]);
      chk("rvalid1", m1_rv, e_rv[1]);
      chk("rdata0", m0_rdata, e_rdata[0]);
      chk("rdata1", m1_rdata, e_rdata[1]);
      chk("err0", m0_err, e_err[0]);
      chk("err1", m1_err, e_err[1]);
      chk("s_cs", s_cs, e_cs);
      chk("s_we", s_we, b_we);
      chk("s_addr", s_addr, b_addr);
      chk("s_wdata", s_wdata, b_wdata);
      if (m0_gnt) begin g_m.push_back(0); g_c.push_back(cyc); end
      if (m1_gnt) begin g_m.push_back(1); g_c.push_back(cyc); end
      if (m0_rv) begin r_m.push_back(0); r_c.push_back(cyc); r_d.push_back(m0_rdata); r_e.push_back(int'(m0_err)); end
      if (m1_rv) begin r_m.push_back(1); r_c.push_back(cyc); r_d.push_back(m1_rdata); r_e.push_back(int'(m1_err)); end
      if (s_cs) cs_hi++;
    end
  end

  task automatic clear_log();
    g_m.delete(); g_c.delete(); r_m.delete(); r_c.delete(); r_d.delete(); r_e.delete();
  endtask

  task automatic wait_gnts(input int n, input string tag);
    int t = 0;
    while (g_m.size() < n && t < 400) begin @(negedge clk); t++; end
    chk({"bound_gnt_", tag}, 64'(g_m.size() >= n), 64'd1);
  endtask

  task automatic wait_rvs(input int n, input string tag);
    int t = 0;
    while (r_m.size() < n && t < 400) begin @(negedge clk); t++; end
    chk({"bound_rv_", tag}, 64'(r_m.size() >= n), 64'd1);
  endtask

  initial begin
    int c0;
    int cs0;
    rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m1_lock = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", s_cs, 0);
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_rv1", m1_rv, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_addr", s_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Contended requests right after reset: m0, m1, m0 back-to-back.
    clear_log();
    sl_wait = 0; sl_data = 64'hA5;
    m0_we = 1; m0_addr = 32'h10; m0_wdata = 64'h11;
    m1_we = 0; m1_addr = 32'h20; m1_wdata = 64'h0;
    m0_req = 1; m1_req = 1;
    wait_gnts(3, "rr");
    m0_req = 0; m1_req = 0;
    wait_rvs(3, "rr");
    chk("rr_g0", qat(g_m, 0), 0);
    chk("rr_g1", qat(g_m, 1), 1);
    chk("rr_g2", qat(g_m, 2), 0);
    chk("rr_r1", qat(r_m, 1), 1);
    chk("rr_gap", qat(g_c, 1) - qat(g_c, 0), 3);
    chk("rr_rdata1", qdat(r_d, 1), 64'hA5);

    // m0 write to a zero-wait slave.
    repeat (2) @(negedge clk);
    clear_log();
    m0_we = 1; m0_addr = 32'd4; m0_wdata = 64'd137;
    c0 = cyc; m0_req = 1;
    wait_gnts(1, "wr");
    chk("wr_gnt_lat", qat(g_c, 0) - c0, 1);
    chk("wr_cs", s_cs, 1);
    chk("wr_we", s_we, 1);
    chk("wr_addr", s_addr, 4);
    chk("wr_wdata", s_wdata, 137);
    m0_req = 0;
    wait_rvs(1, "wr");
    chk("wr_rv_lat", qat(r_c, 0) - c0, 2);
    chk("wr_rv_who", qat(r_m, 0), 0);
    chk("wr_err", qat(r_e, 0), 0);

    // m1 read with two wait states.
    repeat (2) @(negedge clk);
    clear_log();
    sl_wait = 2; sl_data = 64'hFE;
    m1_we = 0; m1_addr = 32'h8;
    c0 = cyc; m1_req = 1;
    wait_gnts(1, "rd");
    m1_req = 0;
    wait_rvs(1, "rd");
    chk("rd_rv_lat", qat(r_c, 0) - c0, 4);
    chk("rd_rv_who", qat(r_m, 0), 1);
    chk("rd_rdata", qdat(r_d, 0), 64'hFE);
    chk("rd_err", qat(r_e, 0), 0);

    // Lock keeps m1 on the bus; releasing it hands the next grant to m0.
    repeat (2) @(negedge clk);
    clear_log();
    sl_wait = 0; sl_data = 64'h33;
    m1_lock = 1; m0_req = 1; m1_req = 1;
    wait_gnts(3, "lk");
    m1_lock = 0;
    wait_gnts(4, "lk2");
    m0_req = 0; m1_req = 0;
    wait_rvs(4, "lk");
    chk("lk_g0", qat(g_m, 0), 1);
    chk("lk_g1", qat(g_m, 1), 1);
    chk("lk_g2", qat(g_m, 2), 1);
    chk("lk_g3", qat(g_m, 3), 0);

    // Ready on the last allowed cycle beats the timeout.
    repeat (2) @(negedge clk);
    clear_log();
    sl_wait = TMO - 1; sl_data = 64'h5A5A;
    cs0 = cs_hi; c0 = cyc; m1_req = 1;
    wait_gnts(1, "edge");
    m1_req = 0;
    wait_rvs(1, "edge");
    chk("edge_rv_lat", qat(r_c, 0) - c0, 16);
    chk("edge_err", qat(r_e, 0), 0);
    chk("edge_rdata", qdat(r_d, 0), 64'h5A5A);
    chk("edge_cs_cyc", cs_hi - cs0, 15);

    // Silent slave: timeout with error and zero data.
    repeat (2) @(negedge clk);
    clear_log();
    sl_wait = -1; sl_data = 64'hDEAD;
    m0_we = 0; m0_addr = 32'h40;
    cs0 = cs_hi; c0 = cyc; m0_req = 1;
    wait_gnts(1, "tmo");
    m0_req = 0;
    wait_rvs(1, "tmo");
    chk("tmo_cs_cyc", cs_hi - cs0, 15);
    chk("tmo_rv_lat", qat(r_c, 0) - c0, 16);
    chk("tmo_rv_who", qat(r_m, 0), 0);
    chk("tmo_err", qat(r_e, 0), 1);
    chk("tmo_rdata", qdat(r_d, 0), 0);

    // Reset during an m1 access: no response, pointer back to m1 so m0 wins next.
    repeat (2) @(negedge clk);
    clear_log();
    m1_req = 1;
    wait_gnts(1, "ab");
    m1_req = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_cs", s_cs, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("ab_no_rv", r_m.size(), 0);
    clear_log();
    sl_wait = 0;
    m0_req = 1; m1_req = 1;
    wait_gnts(1, "ab2");
    m0_req = 0; m1_req = 0;
    chk("ab_first", qat(g_m, 0), 0);
    wait_rvs(1, "ab2");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/as_bus_arbiter.md
# as_bus_arbiter

Two-master arbiter for the RV64I memory-mapped peripheral bus that drives the GPIO block and its `cs` strobe. Master 0 is the core load/store port; master 1 is the JTAG debug master. The arbiter grants one master at a time and forwards the latched request to the single slave. It guards every access with a wait-state timeout. It sits in `as_top_mem` between the core, the debug unit and the GPIO/peripheral decoder.

## Interface
Parameters:
- `ADDR_W`, default `gpio_addr_width`: bus address width.
- `DATA_W`, default 64: bus data width.
- `TMO_CYC`, default 15: maximum slave wait cycles before an error response (≥1).

Ports:
- `clk_i`, in, 1: single clock, rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `m0_req_i`, `m1_req_i`, in, 1: access request; held until grant.
- `m0_we_i`, `m1_we_i`, in, 1: 1 = write, 0 = read.
- `m0_addr_i`, `m1_addr_i`, in, `ADDR_W`: address.
- `m0_wdata_i`, `m1_wdata_i`, in, `DATA_W`: write data.
- `m1_lock_i`, in, 1: debug lock; keeps the bus with master 1 across transactions.
- `m0_gnt_o`, `m1_gnt_o`, out, 1: one-cycle grant pulse; request has been latched.
- `m0_rvalid_o`, `m1_rvalid_o`, out, 1: one-cycle response pulse.
- `m0_rdata_o`, `m1_rdata_o`, out, `DATA_W`: read data; valid with `rvalid`.
- `m0_err_o`, `m1_err_o`, out, 1: timeout flag; valid with `rvalid`.
- `s_cs_o`, out, 1: slave select.
- `s_we_o`, out, 1: slave write enable.
- `s_addr_o`, out, `ADDR_W`: slave address.
- `s_wdata_o`, out, `DATA_W`: slave write data.
- `s_ready_i`, in, 1: slave done; sampled only while `s_cs_o` = 1.
- `s_rdata_i`, in, `DATA_W`: slave read data; sampled together with `s_ready_i`.

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`. All outputs are registered.
- **IDLE** (arbitration):
  - Only one master requesting: that master wins.
  - Both requesting: winner = master not granted last (round-robin).
  - Exception: if `m1_lock_i` = 1 and the last owner was m1, m1 wins.
  - No request: stay in IDLE.
  - On a win: latch we/addr/wdata, pulse the winner's `gnt`, drive `s_cs_o` = 1, go to ACCESS.
- **ACCESS**:
  - Hold `s_cs_o`, `s_we_o`, `s_addr_o`, `s_wdata_o` stable.
  - On `s_ready_i` = 1: capture `s_rdata_i` (writes capture it too; master ignores it), drop `s_cs_o`, go to RESP.
  - Wait counter increments each ACCESS cycle without ready.
  - Counter reaches `TMO_CYC` without ready: drop `s_cs_o`, force rdata = 0 and err = 1, go to RESP.
- **RESP**: pulse owner's `rvalid` with captured rdata/err, update last-owner pointer, go to IDLE.
- Last-owner pointer resets to m1, so m0 wins the first contended arbitration after reset.
- Lock is evaluated only in IDLE. Asserting it mid-transaction does not affect that transaction.
- A master may drop `req` after `gnt`. Keeping `req` high queues its next access.
- `rdata_o` and `err_o` of the non-owner are not updated.

## Timing
- Reset values:
  - all `gnt`, `rvalid`, `err`: 0
  - `rdata`: 0
  - `s_cs_o`, `s_we_o`: 0
  - `s_addr_o`, `s_wdata_o`: 0
  - state: IDLE
  - wait counter: 0
- Latency, with req seen at edge N:
  - `gnt` and `s_cs_o` high in cycle N+1.
  - With a zero-wait slave (ready in N+1): `rvalid` in N+2, IDLE in N+3.
  - Minimum transaction: 3 cycles. Each slave wait state adds 1 cycle.
- Timeout:
  - `s_cs_o` high for exactly `TMO_CYC` cycles.
  - `rvalid` and `err` in the following cycle.
- If `s_ready_i` rises in the same cycle the counter hits `TMO_CYC`: ready wins, err = 0.
- `rst_i` asserted in any state: next cycle is IDLE with reset values.
  - No `rvalid` is issued for the aborted access.
  - Last-owner pointer returns to m1.
- `gnt` and `rvalid` are never asserted to both masters in the same cycle.

## Structure
- `as_pack` holds:
  - the state enum `arb_state_t`
  - the master index typedef
  - the default `TMO_CYC` constant
- One sub-module, `as_arb_rr2`:
  - combinational 2-way round-robin picker with lock override
  - inputs: req[1:0], last, lock
  - output: winner index plus a valid flag
- The FSM, latches and timeout counter stay in `as_bus_arbiter`.

## Test plan
- **m0 write, zero-wait slave.** Drive m0 write addr 4, data 137.
  - `m0_gnt_o` in N+1.
  - `s_cs_o`/`s_we_o` = 1 with addr 4, data 137 in N+1.
  - `m0_rvalid_o` = 1, err = 0 in N+2.
- **Simultaneous requests after reset.** m0 and m1 request in the same cycle and hold req.
  - Grants in the order m0, m1, m0.
  - Each `rvalid` goes to the matching master.
- **Lock.** m1 holds `m1_lock_i` = 1 while both masters request.
  - Three consecutive m1 grants.
  - Drop lock: the next grant goes to m0.
- **Read with 2 wait states.** m1 reads; slave returns ready with rdata 0xFE after 2 wait cycles.
  - `m1_rvalid_o` at N+4 with rdata 0xFE, err 0.
- **Timeout.** Slave never ready, `TMO_CYC` = 15.
  - `s_cs_o` high exactly 15 cycles.
  - Then `m0_rvalid_o` = 1, `m0_err_o` = 1, rdata 0.
- **Reset mid-ACCESS.** Assert `rst_i` during ACCESS.
  - `s_cs_o` = 0 next cycle.
  - No `rvalid`.
  - The next contended arbitration grants m0.
